attn_matrix_source: RTL and testbench
=====================================

ATTN_MATRIX_SOURCE -- requirements
Module: attn_matrix_source

Interface
REQ-001 Parameter N, default 64: elements per matrix (8x8); index width 7 bits.
REQ-002 Parameter TIMEOUT_CYC, default 250: max cycles from end of stream to first result.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 load_we  input  1  write strobe into the selected operand memory.
REQ-006 load_sel  input  2  operand select: 0=Q, 1=K, 2=V, 3=ignored.
REQ-007 load_addr  input  6  element index 0..63, row-major.
REQ-008 load_data  input  4  unsigned element value.
REQ-009 start  input  1  one-cycle pulse that begins a stream/collect run.
REQ-010 busy  output  1  high from accepted start until FINISH is entered.
REQ-011 matrix_q, matrix_k, matrix_v  output  4 each  streamed operand elements.
REQ-012 en  output  1  qualifies matrix_q/k/v; high for exactly N consecutive cycles per run.
REQ-013 done  input  1  result-valid strobe from the attention engine.
REQ-014 answer  input  18  result element, valid when done=1.
REQ-015 res_rd_addr  input  6  result buffer read address.
REQ-016 res_rd_data  output  18  result buffer data, combinational read.
REQ-017 res_count  output  7  number of results captured in the current run, 0..64.
REQ-018 complete  output  1  high when all N results captured; held until next accepted start.
REQ-019 timeout  output  1  high when no result arrived within TIMEOUT_CYC; held until next accepted start.

Function
REQ-020 FSM states IDLE, STREAM, WAIT, FINISH; FINISH returns to IDLE after one cycle.
REQ-021 IDLE: start=1 -> STREAM; clears res_count, complete, timeout, index.
REQ-022 STREAM: en=1, matrix_x = mem_x[index], registered; first en cycle is the cycle after start is sampled.
REQ-023 index increments each STREAM cycle; after index 63 is presented -> WAIT (or FINISH if res_count already N).
REQ-024 Outside STREAM, en=0 and matrix_q/k/v = 0.
REQ-025 Loads accepted only in IDLE; load_we while busy or load_sel=3 is ignored.
REQ-026 done is sampled in STREAM and WAIT: answer written to buffer[res_count], res_count increments next cycle.
REQ-027 done in IDLE or FINISH, or with res_count=N, is ignored (no write, no increment).
REQ-028 res_count reaching N -> FINISH, complete=1.
REQ-029 Timeout counter starts at 0 on first WAIT cycle, increments per WAIT cycle while res_count=0; reaching TIMEOUT_CYC -> FINISH, timeout=1.
REQ-030 Once res_count>0 timeout cannot assert; WAIT persists until N results.
REQ-031 start while busy is ignored; start and done in same cycle in IDLE: start wins, done ignored.
REQ-032 res_rd_data readable at any time; contents persist until overwritten by a later run.

Reset
REQ-033 reset low asynchronously forces IDLE, en=0, matrix_q/k/v=0, busy=0, res_count=0, complete=0, timeout=0, index=0, timeout counter=0.
REQ-034 Operand and result memories are not reset; reset mid-run aborts the run, first cycle after release is IDLE.

Structure
REQ-035 Shared package holds N, TIMEOUT_CYC default, element widths (4, 18), load_sel encodings and FSM state typedef.
REQ-036 One sub-module, attn_operand_mem: 64x4 single-write, single-read memory, instantiated three times (Q, K, V).

Verification
REQ-037 Load Q[i]=i%16, K=15-i%16, V=7; start -> en high 64 cycles, cycle k shows Q=k%16, K=15-k%16, V=7.
REQ-038 Echo model drives done/answer=ans_index*3 starting 10 cycles after last en -> res_count=64, complete=1, buffer[63]=189.
REQ-039 No done after stream -> timeout=1 exactly 250 cycles after first WAIT cycle, complete=0, busy drops.
REQ-040 Second start pulse at stream cycle 20 and load_we during stream -> no effect; stream and memories unchanged.
REQ-041 reset asserted at stream cycle 30 -> en=0, matrix outputs 0 immediately; new start after release streams from index 0.
REQ-042 Done for 70 cycles in WAIT -> res_count saturates at 64, buffer entries 0..63 only, extra done ignored.

Source files
------------

// File: rtl/attn_matrix_source_pkg.sv
// Shared constants, load-select encodings and FSM state type for the
// attention matrix source block.
package attn_matrix_source_pkg;

    localparam int N_DEF       = 64;
    localparam int TIMEOUT_DEF = 250;
    localparam int IDX_W       = 7;
    localparam int ADDR_W      = 6;
    localparam int EL_W        = 4;
    localparam int RES_W       = 18;

    localparam logic [1:0] SEL_Q    = 2'd0;
    localparam logic [1:0] SEL_K    = 2'd1;
    localparam logic [1:0] SEL_V    = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/attn_operand_mem.sv
// 64x4 operand store: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module attn_operand_mem
    import attn_matrix_source_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [EL_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [EL_W-1:0]   rd_data
);

    logic [EL_W-1:0] mem [1<<ADDR_W];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/attn_matrix_source.sv
// Streams Q/K/V operand matrices to the attention engine, then collects
// its results into a readable buffer with a first-result timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | operand loads accepted, waiting for start
// ST_STREAM | en high, one element of Q/K/V presented per cycle
// ST_WAIT   | stream done, collecting results / watching for timeout
// ST_FINISH | one cycle: all results captured or timed out, back to idle
module attn_matrix_source
    import attn_matrix_source_pkg::*;
#(
    parameter int N           = N_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_we,
    input  logic [1:0]        load_sel,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [EL_W-1:0]   load_data,
    input  logic              start,
    output logic              busy,
    output logic [EL_W-1:0]   matrix_q,
    output logic [EL_W-1:0]   matrix_k,
    output logic [EL_W-1:0]   matrix_v,
    output logic              en,
    input  logic              done,
    input  logic [RES_W-1:0]  answer,
    input  logic [ADDR_W-1:0] res_rd_addr,
    output logic [RES_W-1:0]  res_rd_data,
    output logic [IDX_W-1:0]  res_count,
    output logic              complete,
    output logic              timeout
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDX_W-1:0] N_IDX   = IDX_W'(N);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   index;
    logic [TO_W-1:0]    to_cnt;
    logic [ADDR_W-1:0]  rd_addr;
    logic [EL_W-1:0]    rd_q, rd_k, rd_v;
    logic [RES_W-1:0]   res_buf [1<<ADDR_W];
    logic               load_ok, done_acc, last_res, stream_last, to_hit;

    assign load_ok     = load_we && (state == ST_IDLE) && (load_sel != SEL_NONE);
    assign done_acc    = done && ((state == ST_STREAM) || (state == ST_WAIT)) && (res_count != N_IDX);
    assign last_res    = done_acc && (res_count == N_IDX - 7'd1);
    assign stream_last = (state == ST_STREAM) && (index == N_IDX);
    assign to_hit      = (state == ST_WAIT) && (res_count == '0) && !done_acc && (to_cnt == TO_LAST);

    // In idle the read port is parked on element 0 so the first element
    // is ready to register on the start edge.
    assign rd_addr = (state == ST_IDLE) ? '0 : index[ADDR_W-1:0];

    assign en          = (state == ST_STREAM);
    assign busy        = (state == ST_STREAM) || (state == ST_WAIT);
    assign res_rd_data = res_buf[res_rd_addr];

    attn_operand_mem u_mem_q (.clk(clk), .we(load_ok && (load_sel == SEL_Q)), .wr_addr(load_addr),
                              .wr_data(load_data), .rd_addr(rd_addr), .rd_data(rd_q));
    attn_operand_mem u_mem_k (.clk(clk), .we(load_ok && (load_sel == SEL_K)), .wr_addr(load_addr),
                              .wr_data(load_data), .rd_addr(rd_addr), .rd_data(rd_k));
    attn_operand_mem u_mem_v (.clk(clk), .we(load_ok && (load_sel == SEL_V)), .wr_addr(load_addr),
                              .wr_data(load_data), .rd_addr(rd_addr), .rd_data(rd_v));

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_STREAM;
            ST_STREAM: if (stream_last) state_nxt = ((res_count == N_IDX) || last_res) ? ST_FINISH : ST_WAIT;
            ST_WAIT:   if (last_res || (res_count == N_IDX) || to_hit) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // stream index, output registers, result count and status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            index     <= '0;
            to_cnt    <= '0;
            res_count <= '0;
            complete  <= 1'b0;
            timeout   <= 1'b0;
            matrix_q  <= '0;
            matrix_k  <= '0;
            matrix_v  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        index     <= 7'd1;
                        to_cnt    <= '0;
                        res_count <= '0;
                        complete  <= 1'b0;
                        timeout   <= 1'b0;
                        matrix_q  <= rd_q;
                        matrix_k  <= rd_k;
                        matrix_v  <= rd_v;
                    end
                end
                ST_STREAM: begin
                    if (stream_last) begin
                        matrix_q <= '0;
                        matrix_k <= '0;
                        matrix_v <= '0;
                    end else begin
                        matrix_q <= rd_q;
                        matrix_k <= rd_k;
                        matrix_v <= rd_v;
                        index    <= index + 7'd1;
                    end
                end
                ST_WAIT: begin
                    if (to_hit) begin
                        timeout <= 1'b1;
                    end else if ((res_count == '0) && !done_acc) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
            if (done_acc) begin
                res_count <= res_count + 7'd1;
                if (last_res) begin
                    complete <= 1'b1;
                end
            end
        end
    end

    // result capture; buffer is not reset so results survive until overwritten
    always_ff @(posedge clk) begin
        if (done_acc) begin
            res_buf[res_count[ADDR_W-1:0]] <= answer;
        end
    end

endmodule

// File: tb/tb_attn_matrix_source.sv
// Bench for attn_matrix_source: streamed operands are scored against a
// queue of expected elements; result capture, timeout, ignored start/load,
// mid-run reset and done saturation are checked directly.
module tb_attn_matrix_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_we;
    logic [1:0]  load_sel;
    logic [5:0]  load_addr;
    logic [3:0]  load_data;
    logic        start;
    logic        busy;
    logic [3:0]  matrix_q, matrix_k, matrix_v;
    logic        en;
    logic        done;
    logic [17:0] answer;
    logic [5:0]  res_rd_addr;
    logic [17:0] res_rd_data;
    logic [6:0]  res_count;
    logic        complete;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    logic [11:0] exp_q [$];
    logic [3:0]  mq [64];
    logic [3:0]  mk [64];
    logic [3:0]  mv [64];

    attn_matrix_source dut (
        .clk(clk), .reset(reset), .load_we(load_we), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .start(start), .busy(busy),
        .matrix_q(matrix_q), .matrix_k(matrix_k), .matrix_v(matrix_v), .en(en),
        .done(done), .answer(answer), .res_rd_addr(res_rd_addr),
        .res_rd_data(res_rd_data), .res_count(res_count), .complete(complete),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input int addr, input logic [3:0] data);
        load_we   = 1'b1;
        load_sel  = sel;
        load_addr = 6'(addr);
        load_data = data;
        tick();
        load_we   = 1'b0;
    endtask

    task automatic push_stream();
        for (int i = 0; i < 64; i++) exp_q.push_back({mq[i], mk[i], mv[i]});
    endtask

    task automatic wait_en(input logic val, input string tag);
        int n;
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (en === val) break;
        end
        chk(tag, n < 300, 1);
    endtask

    task automatic read_buf(input int addr, input int exp, input string tag);
        res_rd_addr = 6'(addr);
        #1;
        chk(tag, res_rd_data, exp);
    endtask

    // scoreboard: every en cycle pops one expected element; otherwise outputs are 0
    always @(negedge clk) begin
        if (reset) begin
            if (en) begin
                en_cnt++;
                chk("stream_queue", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("stream_elem", {matrix_q, matrix_k, matrix_v}, exp_q.pop_front());
            end else begin
                chk("idle_zero", {matrix_q, matrix_k, matrix_v}, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1; load_we = 0; load_sel = 0; load_addr = 0; load_data = 0;
        start = 0; done = 0; answer = 0; res_rd_addr = 0;
        #3 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", en, 0);
        chk("rst_mat", {matrix_q, matrix_k, matrix_v}, 0);
        chk("rst_cnt", res_count, 0);
        chk("rst_complete", complete, 0);
        chk("rst_timeout", timeout, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 64; i++) begin
            mq[i] = 4'(i % 16);
            mk[i] = 4'(15 - i % 16);
            mv[i] = 4'd7;
            load(2'd0, i, mq[i]);
            load(2'd1, i, mk[i]);
            load(2'd2, i, mv[i]);
        end
        load(2'd3, 2, 4'd9);

        // run A: full stream, ignored start/load at stream cycle 20, echo results
        push_stream();
        en_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        chk("a_en_first", en, 1);
        repeat (20) tick();
        start = 1'b1; load_we = 1'b1; load_sel = 2'd0; load_addr = 6'd5; load_data = 4'd0;
        tick();
        start = 1'b0; load_we = 1'b0;
        wait_en(1'b0, "a_stream_end");
        chk("a_en_cnt", en_cnt, 64);
        chk("a_wait_busy", busy, 1);
        chk("a_wait_cnt", res_count, 0);
        chk("a_wait_complete", complete, 0);
        repeat (9) @(posedge clk);
        #1;
        done = 1'b1;
        for (int i = 0; i < 64; i++) begin
            answer = 18'(i * 3);
            tick();
        end
        done = 1'b0;
        chk("a_cnt", res_count, 64);
        chk("a_complete", complete, 1);
        chk("a_busy", busy, 0);
        chk("a_timeout", timeout, 0);
        read_buf(63, 189, "a_buf63");
        read_buf(0, 0, "a_buf0");
        read_buf(17, 51, "a_buf17");
        repeat (3) tick();
        chk("a_complete_held", complete, 1);

        // run B: no results -> timeout 250 cycles after first wait cycle
        push_stream();
        en_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        wait_en(1'b0, "b_stream_end");
        chk("b_en_cnt", en_cnt, 64);
        chk("b_timeout_early", timeout, 0);
        chk("b_complete_clr", complete, 0);
        for (n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (timeout) break;
        end
        chk("b_timeout_cycles", n, 250);
        chk("b_complete", complete, 0);
        chk("b_busy", busy, 0);
        chk("b_cnt", res_count, 0);
        read_buf(63, 189, "b_buf_persist");
        repeat (3) tick();
        chk("b_timeout_held", timeout, 1);

        // run C: reset at stream cycle 30, then restart with start+done together
        push_stream();
        en_cnt = 0;
        start = 1'b1; tick(); start = 1'b0;
        repeat (30) tick();
        reset = 1'b0;
        #1;
        chk("c_rst_en", en, 0);
        chk("c_rst_mat", {matrix_q, matrix_k, matrix_v}, 0);
        chk("c_rst_busy", busy, 0);
        chk("c_rst_timeout", timeout, 0);
        chk("c_en_before_rst", en_cnt, 30);
        exp_q.delete();
        #2 reset = 1'b1;
        tick();
        chk("c_idle_busy", busy, 0);
        chk("c_idle_cnt", res_count, 0);
        push_stream();
        en_cnt = 0;
        start = 1'b1; done = 1'b1; answer = 18'h3FFFF;
        tick();
        start = 1'b0; done = 1'b0;
        chk("c_en_first", en, 1);
        wait_en(1'b0, "c_stream_end");
        chk("c_en_cnt", en_cnt, 64);
        chk("c_cnt_ignored", res_count, 0);
        repeat (3) tick();
        done = 1'b1;
        for (int i = 0; i < 70; i++) begin
            answer = 18'(1000 + i);
            tick();
        end
        done = 1'b0;
        tick();
        chk("c_cnt_sat", res_count, 64);
        chk("c_complete", complete, 1);
        chk("c_timeout", timeout, 0);
        chk("c_busy", busy, 0);
        read_buf(63, 1063, "c_buf63");
        read_buf(0, 1000, "c_buf0");
        read_buf(40, 1040, "c_buf40");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
